// File: rtl/pcileech_ft601_emu_pkg.sv
`default_nettype none
// ============================================================================
// pcileech_ft601_emu_pkg : shared types and constants for the FT601 emulator
// Revision: 1.0 - initial release
// ============================================================================
package pcileech_ft601_emu_pkg;
    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_TURN   = 2'd1,
        RD_ACTIVE = 2'd2,
        WR_ACTIVE = 2'd3
    } state_t;
endpackage
`default_nettype wire

// File: rtl/pcileech_ft601_emu_fifo.sv
`default_nettype none
// ============================================================================
// pcileech_ft601_emu_fifo : first-word-fall-through FIFO with count and flush
// Revision: 1.0 - initial release
// ============================================================================
module pcileech_ft601_emu_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DEPTH_LOG2:0]   count_next,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (do_push && !do_pop)
            count_next = count + CNT_ONE;
        else if (do_pop && !do_push)
            count_next = count - CNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_next;
        end
    end

    // Storage kept out of the reset domain so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= push_data;
    end
endmodule
`default_nettype wire

// File: rtl/pcileech_ft601_emu.sv
`default_nettype none
// ============================================================================
// pcileech_ft601_emu : FT601 245 sync-FIFO chip-side emulator
// Optional backpressure stress: PCILEECH_FT601_EMU_THROTTLE_EN
// Revision: 1.0 - initial release
// ============================================================================
module pcileech_ft601_emu
    import pcileech_ft601_emu_pkg::*;
#(
    parameter int RX_DEPTH_LOG2 = 9,
    parameter int TX_DEPTH_LOG2 = 9,
    parameter int TXE_MARGIN    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] host_rx_data,
    input  logic              host_rx_valid,
    output logic              host_rx_ready,
    output logic [WORD_W-1:0] host_tx_data,
    output logic [BE_W-1:0]   host_tx_be,
    output logic              host_tx_valid,
    input  logic              host_tx_ready,
    input  logic              ft601_rst_n,
    input  logic [WORD_W-1:0] ft601_data_i,
    output logic [WORD_W-1:0] ft601_data_o,
    output logic              ft601_data_oe,
    input  logic [BE_W-1:0]   ft601_be_i,
    output logic [BE_W-1:0]   ft601_be_o,
    output logic              ft601_rxf_n,
    output logic              ft601_txe_n,
    input  logic              ft601_wr_n,
    input  logic              ft601_rd_n,
    input  logic              ft601_oe_n,
    input  logic              ft601_siwu_n,
    output logic              proto_err
);
    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam logic [TX_DEPTH_LOG2:0] TXE_THRESH = (TX_DEPTH_LOG2+1)'(TX_DEPTH - TXE_MARGIN);

    logic                     flush;
    logic                     alive;
    logic                     force_busy;
    logic                     rd_pop;
    logic                     wr_push;
    logic                     violation;
    logic [WORD_W-1:0]        last_word;
    state_t                   state;

    logic [WORD_W-1:0]        rx_head;
    logic [RX_DEPTH_LOG2:0]   rx_count_unused;
    logic [RX_DEPTH_LOG2:0]   rx_count_next;
    logic                     rx_full;
    logic                     rx_empty;
    logic [WORD_W+BE_W-1:0]   tx_head;
    logic [TX_DEPTH_LOG2:0]   tx_count_unused;
    logic [TX_DEPTH_LOG2:0]   tx_count_next;
    logic                     tx_full;
    logic                     tx_empty;
    logic                     siwu_unused;

    assign siwu_unused   = ft601_siwu_n;
    assign flush         = ~ft601_rst_n;
    assign host_rx_ready = alive & ~rx_full;
    assign host_tx_valid = ~tx_empty;
    assign host_tx_data  = tx_head[WORD_W+BE_W-1:BE_W];
    assign host_tx_be    = tx_head[BE_W-1:0];
    assign ft601_be_o    = {BE_W{1'b1}};
    // An empty RX FIFO keeps presenting the most recently popped word.
    assign ft601_data_o  = rx_empty ? last_word : rx_head;
    assign wr_push       = ~ft601_wr_n & ~ft601_txe_n & ~tx_full;
    assign violation     = (~ft601_wr_n & ~ft601_oe_n) | (~ft601_rd_n & ft601_oe_n);

`ifdef PCILEECH_FT601_EMU_THROTTLE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else if (flush)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign force_busy = (lfsr[2:0] == 3'd0);
    assign rd_pop     = ~ft601_rd_n & ~ft601_oe_n & ft601_data_oe & ~ft601_rxf_n & ~rx_empty;
`else
    assign force_busy = 1'b0;
    assign rd_pop     = ~ft601_rd_n & ~ft601_oe_n & ft601_data_oe & ~rx_empty;
`endif

    pcileech_ft601_emu_fifo #(.WIDTH(WORD_W), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (host_rx_valid & host_rx_ready),
        .push_data  (host_rx_data),
        .pop        (rd_pop),
        .head       (rx_head),
        .count      (rx_count_unused),
        .count_next (rx_count_next),
        .full       (rx_full),
        .empty      (rx_empty)
    );

    pcileech_ft601_emu_fifo #(.WIDTH(WORD_W+BE_W), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (wr_push),
        .push_data  ({ft601_data_i, ft601_be_i}),
        .pop        (host_tx_ready & ~tx_empty),
        .head       (tx_head),
        .count      (tx_count_unused),
        .count_next (tx_count_next),
        .full       (tx_full),
        .empty      (tx_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ft601_data_oe <= 1'b0;
            ft601_rxf_n   <= 1'b1;
            ft601_txe_n   <= 1'b1;
            proto_err     <= 1'b0;
            alive         <= 1'b0;
            last_word     <= '0;
        end else if (flush) begin
            state         <= IDLE;
            ft601_data_oe <= 1'b0;
            ft601_rxf_n   <= 1'b1;
            ft601_txe_n   <= 1'b1;
            proto_err     <= 1'b0;
            alive         <= 1'b0;
            last_word     <= '0;
        end else begin
            alive         <= 1'b1;
            ft601_data_oe <= ~ft601_oe_n;
            ft601_rxf_n   <= (rx_count_next == '0) | force_busy;
            ft601_txe_n   <= (tx_count_next >= TXE_THRESH) | force_busy;
            if (rd_pop)    last_word <= rx_head;
            if (violation) proto_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (!ft601_oe_n && ft601_wr_n)
                        state <= RD_TURN;
                    else if (!ft601_wr_n && ft601_oe_n)
                        state <= WR_ACTIVE;
                end
                RD_TURN: begin
                    if (ft601_oe_n)
                        state <= IDLE;
                    else if (!ft601_rd_n)
                        state <= RD_ACTIVE;
                end
                RD_ACTIVE: begin
                    if (ft601_oe_n)
                        state <= IDLE;
                    else if (ft601_rd_n)
                        state <= RD_TURN;
                end
                WR_ACTIVE: begin
                    if (ft601_wr_n)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pcileech_ft601_emu.sv
`default_nettype none
// ============================================================================
// tb_pcileech_ft601_emu : randomized bench with queue-based reference model
// Revision: 1.0 - initial release
// ============================================================================
module tb_pcileech_ft601_emu;
    localparam int DEPTH  = 512;
    localparam int MARGIN = 4;
`ifdef PCILEECH_FT601_EMU_THROTTLE_EN
    localparam int N_STREAM = 1000;
`else
    localparam int N_STREAM = 300;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] host_rx_data;
    logic        host_rx_valid;
    logic        host_rx_ready;
    logic [31:0] host_tx_data;
    logic [3:0]  host_tx_be;
    logic        host_tx_valid;
    logic        host_tx_ready;
    logic        ft601_rst_n;
    logic [31:0] ft601_data_i;
    logic [31:0] ft601_data_o;
    logic        ft601_data_oe;
    logic [3:0]  ft601_be_i;
    logic [3:0]  ft601_be_o;
    logic        ft601_rxf_n;
    logic        ft601_txe_n;
    logic        ft601_wr_n;
    logic        ft601_rd_n;
    logic        ft601_oe_n;
    logic        ft601_siwu_n;
    logic        proto_err;

    always #5 clk = ~clk;

    pcileech_ft601_emu dut (
        .clk(clk), .rst(rst),
        .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
        .host_tx_data(host_tx_data), .host_tx_be(host_tx_be), .host_tx_valid(host_tx_valid),
        .host_tx_ready(host_tx_ready), .ft601_rst_n(ft601_rst_n),
        .ft601_data_i(ft601_data_i), .ft601_data_o(ft601_data_o), .ft601_data_oe(ft601_data_oe),
        .ft601_be_i(ft601_be_i), .ft601_be_o(ft601_be_o),
        .ft601_rxf_n(ft601_rxf_n), .ft601_txe_n(ft601_txe_n),
        .ft601_wr_n(ft601_wr_n), .ft601_rd_n(ft601_rd_n), .ft601_oe_n(ft601_oe_n),
        .ft601_siwu_n(ft601_siwu_n), .proto_err(proto_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: word queues plus the few bits of bus history that matter.
    logic [31:0] rx_q[$];
    logic [35:0] tx_q[$];
    bit          oe_prev_m;
    bit          err_m;
    int          rx_popped;
    int          tx_recv;
    bit          last_rxp;
    bit          last_txp;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        host_rx_valid = 1'b0;
        host_tx_ready = 1'b0;
        ft601_rst_n   = 1'b1;
        ft601_wr_n    = 1'b1;
        ft601_rd_n    = 1'b1;
        ft601_oe_n    = 1'b1;
        ft601_siwu_n  = 1'b1;
    endtask

    task automatic clear_model();
        rx_q.delete();
        tx_q.delete();
        oe_prev_m = 1'b0;
        err_m     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        clear_model();
    endtask

    // One bus cycle: predict transfers from the model, check, clock, update.
    task automatic step();
        bit rxp, rxo, txp, txo, rxf_ok, txe_ok;
        logic [31:0] hd;
        logic [35:0] wd;
`ifdef PCILEECH_FT601_EMU_THROTTLE_EN
        rxf_ok = !ft601_rxf_n;
        txe_ok = !ft601_txe_n;
`else
        check_eq("rxf_n", ft601_rxf_n, rx_q.size() == 0);
        check_eq("txe_n", ft601_txe_n, (DEPTH - tx_q.size()) <= MARGIN);
        rxf_ok = rx_q.size() != 0;
        txe_ok = (DEPTH - tx_q.size()) > MARGIN;
`endif
        check_eq("data_oe", ft601_data_oe, oe_prev_m);
        check_eq("host_tx_valid", host_tx_valid, tx_q.size() != 0);
        check_eq("host_rx_ready", host_rx_ready, rx_q.size() < DEPTH);
        check_eq("proto_err", proto_err, err_m);
        rxp = host_rx_valid && rx_q.size() < DEPTH;
        rxo = !ft601_rd_n && !ft601_oe_n && oe_prev_m && rxf_ok && rx_q.size() != 0;
        if (rxo) check_eq("rd_word", ft601_data_o, rx_q[0]);
        txp = !ft601_wr_n && txe_ok && tx_q.size() < DEPTH;
        txo = host_tx_ready && tx_q.size() != 0;
        if (txo) begin
            check_eq("tx_data", host_tx_data, tx_q[0][35:4]);
            check_eq("tx_be", host_tx_be, tx_q[0][3:0]);
        end
        if ((!ft601_wr_n && !ft601_oe_n) || (!ft601_rd_n && ft601_oe_n)) err_m = 1'b1;
        hd = host_rx_data;
        wd = {ft601_data_i, ft601_be_i};
        @(posedge clk); #1;
        if (rxo) begin void'(rx_q.pop_front()); rx_popped++; end
        if (rxp) rx_q.push_back(hd);
        if (txo) begin void'(tx_q.pop_front()); tx_recv++; end
        if (txp) tx_q.push_back(wd);
        oe_prev_m = !ft601_oe_n;
        last_rxp  = rxp;
        last_txp  = txp;
    endtask

    initial begin
        logic [31:0] wdat [2];
        logic [3:0]  wbe  [2];
        logic [31:0] rx_word, tx_word;
        logic [3:0]  tx_be;
        int          rx_sent, tx_sent, phase_left, cyc;
        bit          rd_mode;

        host_rx_data = '0;
        ft601_data_i = '0;
        ft601_be_i   = '0;
        idle_inputs();
        rx_popped = 0;
        tx_recv   = 0;
        clear_model();

        // Reset state while rst is held.
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_rxf_n", ft601_rxf_n, 1'b1);
        check_eq("rst_txe_n", ft601_txe_n, 1'b1);
        check_eq("rst_data_oe", ft601_data_oe, 1'b0);
        check_eq("rst_data_o", ft601_data_o, 32'h0);
        check_eq("rst_proto_err", proto_err, 1'b0);
        check_eq("rst_tx_valid", host_tx_valid, 1'b0);
        check_eq("rst_rx_ready", host_rx_ready, 1'b0);
        check_eq("be_o", ft601_be_o, 4'hf);
        rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        // Host pushes three words, master reads them back.
        for (int i = 0; i < 3; i++) begin
            host_rx_data  = 32'h11111111 * (i + 1);
            host_rx_valid = 1'b1;
            step();
        end
        host_rx_valid = 1'b0;
        ft601_oe_n = 1'b0;
        step();
        ft601_rd_n = 1'b0;
        rx_popped = 0;
        for (int i = 0; i < 60 && rx_q.size() != 0; i++) step();
        check_eq("rd_count", rx_popped, 3);
        step();
        check_eq("rd_hold", ft601_data_o, 32'h33333333);
        check_eq("rd_rxf_empty", ft601_rxf_n, 1'b1);
        ft601_rd_n = 1'b1;
        ft601_oe_n = 1'b1;
        step();

        // Master writes two words with distinct byte enables.
        wdat[0] = 32'hDEADBEEF; wbe[0] = 4'h3;
        wdat[1] = 32'hCAFEBABE; wbe[1] = 4'hf;
        for (int w = 0; w < 2; w++) begin
            ft601_data_i = wdat[w];
            ft601_be_i   = wbe[w];
            ft601_wr_n   = 1'b0;
            last_txp     = 1'b0;
            for (int i = 0; i < 40 && !last_txp; i++) step();
            check_eq("wr_accept", last_txp, 1'b1);
            ft601_wr_n = 1'b1;
        end
        step();
        check_eq("wr_valid", host_tx_valid, 1'b1);
        check_eq("wr_data0", host_tx_data, 32'hDEADBEEF);
        check_eq("wr_be0", host_tx_be, 4'h3);
        host_tx_ready = 1'b1;
        step();
        check_eq("wr_data1", host_tx_data, 32'hCAFEBABE);
        check_eq("wr_be1", host_tx_be, 4'hf);
        step();
        host_tx_ready = 1'b0;
        step();

        // Fill TX up to the margin, then release one slot.
        ft601_wr_n = 1'b0;
        for (int i = 0; i < 4000 && tx_q.size() < DEPTH - MARGIN; i++) begin
            ft601_data_i = $urandom;
            ft601_be_i   = 4'($urandom);
            step();
        end
        for (int i = 0; i < 3; i++) step();
        check_eq("fill_txe_n", ft601_txe_n, 1'b1);
        ft601_wr_n    = 1'b1;
        host_tx_ready = 1'b1;
        step();
        host_tx_ready = 1'b0;
        step();
        host_tx_ready = 1'b1;
        for (int i = 0; i < 700 && tx_q.size() != 0; i++) step();
        host_tx_ready = 1'b0;
        step();

        // Protocol violations are sticky until reset.
        ft601_wr_n = 1'b0;
        ft601_oe_n = 1'b0;
        step();
        ft601_wr_n = 1'b1;
        ft601_oe_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check_eq("err_wr_oe", proto_err, 1'b1);
        do_reset();
        check_eq("err_cleared", proto_err, 1'b0);
        ft601_rd_n = 1'b0;
        step();
        ft601_rd_n = 1'b1;
        step();
        check_eq("err_rd_no_oe", proto_err, 1'b1);
        do_reset();

        // Asynchronous reset in the middle of a read burst.
        for (int i = 0; i < 4; i++) begin
            host_rx_data  = $urandom;
            host_rx_valid = 1'b1;
            step();
        end
        host_rx_valid = 1'b0;
        ft601_oe_n = 1'b0;
        step();
        ft601_rd_n = 1'b0;
        step();
        #3 rst = 1'b1;
        #1;
        check_eq("arst_rxf_n", ft601_rxf_n, 1'b1);
        check_eq("arst_data_oe", ft601_data_oe, 1'b0);
        check_eq("arst_txe_n", ft601_txe_n, 1'b1);
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        clear_model();
        check_eq("arst_rx_empty", ft601_rxf_n, 1'b1);
        step();

        // Bus reset from the master flushes both FIFOs synchronously.
        host_rx_data  = 32'h5A5A5A5A;
        host_rx_valid = 1'b1;
        step();
        step();
        host_rx_valid = 1'b0;
        ft601_rst_n   = 1'b0;
        @(posedge clk); #1;
        ft601_rst_n = 1'b1;
        check_eq("flush_rxf_n", ft601_rxf_n, 1'b1);
        check_eq("flush_tx_valid", host_tx_valid, 1'b0);
        @(posedge clk); #1;
        clear_model();
        step();

        // Randomized bidirectional streaming.
        rx_popped  = 0;
        tx_recv    = 0;
        rx_sent    = 0;
        tx_sent    = 0;
        phase_left = 0;
        rd_mode    = 1'b0;
        rx_word    = $urandom;
        tx_word    = $urandom;
        tx_be      = 4'($urandom);
        cyc        = 0;
        while (cyc < 40000 && (rx_popped < N_STREAM || tx_recv < N_STREAM)) begin
            host_rx_data  = rx_word;
            host_rx_valid = (rx_sent < N_STREAM) && ($urandom_range(0, 3) != 0);
            host_tx_ready = ($urandom_range(0, 3) != 0);
            if (phase_left == 0) begin
                rd_mode    = $urandom_range(0, 1) == 1;
                phase_left = $urandom_range(4, 20);
            end
            phase_left--;
            ft601_data_i = tx_word;
            ft601_be_i   = tx_be;
            if (rd_mode) begin
                ft601_oe_n = 1'b0;
                ft601_wr_n = 1'b1;
                ft601_rd_n = ($urandom_range(0, 4) == 0);
            end else begin
                ft601_oe_n = 1'b1;
                ft601_rd_n = 1'b1;
                ft601_wr_n = !((tx_sent < N_STREAM) && ($urandom_range(0, 3) != 0));
            end
            step();
            if (last_rxp) begin rx_sent++; rx_word = $urandom; end
            if (last_txp) begin tx_sent++; tx_word = $urandom; tx_be = 4'($urandom); end
            cyc++;
        end
        check_eq("stream_rx_words", rx_popped, N_STREAM);
        check_eq("stream_tx_words", tx_recv, N_STREAM);
        check_eq("stream_proto_err", proto_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pcileech_ft601_emu.md
Name: pcileech_ft601_emu

Overview:
Synthesizable model of the FT601 chip side of the 245 synchronous-FIFO bus; the peer of the FT601 master logic in pcileech_com.
- Host side: valid/ready word streams.
- FPGA side: FT601 pad-level signals, with the tristate bus split into in/out/oe.
- Used in block-level simulation of pcileech_com, and on a second board as a hardware-in-loop host emulator.
- Runs on ft601_clk, presented to this block as its single clock.

Parameters:
RX_DEPTH_LOG2, 9, log2 depth of the host->FPGA word FIFO (512 words).
TX_DEPTH_LOG2, 9, log2 depth of the FPGA->host word FIFO (512 words).
TXE_MARGIN, 4, free TX slots at or below which ft601_txe_n is deasserted.

Ports:
clk  in  1  bus clock (FT601 clock domain).
rst  in  1  reset, asynchronous, active-high.
host_rx_data  in  32  word to send to the FPGA.
host_rx_valid  in  1  host_rx_data valid.
host_rx_ready  out  1  RX FIFO not full.
host_tx_data  out  32  word received from the FPGA.
host_tx_be  out  4  byte enables of host_tx_data.
host_tx_valid  out  1  TX FIFO not empty.
host_tx_ready  in  1  host consumes a word.
ft601_rst_n  in  1  master-driven bus reset, synchronous flush.
ft601_data_i  in  32  bus data driven by the master.
ft601_data_o  out  32  bus data driven by the emulator.
ft601_data_oe  out  1  emulator drives data/be.
ft601_be_i  in  4  byte enables from the master.
ft601_be_o  out  4  byte enables to the master (always 4'hf).
ft601_rxf_n  out  1  low = read data available.
ft601_txe_n  out  1  low = write space available.
ft601_wr_n  in  1  master write strobe.
ft601_rd_n  in  1  master read strobe.
ft601_oe_n  in  1  master output-enable request.
ft601_siwu_n  in  1  ignored, reserved.
proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset values: rxf_n=1, txe_n=1, data_oe=0, data_o=0, proto_err=0, host_tx_valid=0, host_rx_ready=0; both FIFOs empty; FSM in IDLE.
- ft601_rst_n low for any cycle has the same effect as rst, except that it is synchronous.
- Both FIFOs are first-word-fall-through with an occupancy count. Push and pop in the same cycle leave the count unchanged.
- Registered flags: ft601_rxf_n <= (next_rx_count==0); ft601_txe_n <= (TX_DEPTH - next_tx_count <= TXE_MARGIN).
- host_rx_ready = RX not full. host_tx_valid = TX not empty. host_tx_data/host_tx_be = TX head word.
- FSM states and transitions:
  - IDLE -> RD_TURN when oe_n=0 and wr_n=1.
  - IDLE -> WR_ACTIVE when wr_n=0 and oe_n=1.
  - RD_TURN -> RD_ACTIVE when rd_n=0.
  - RD_TURN and RD_ACTIVE -> IDLE when oe_n=1.
  - RD_ACTIVE -> RD_TURN when rd_n=1 and oe_n=0.
  - WR_ACTIVE -> IDLE when wr_n=1.
- Read path:
  - data_oe = registered (~oe_n), so there is one turnaround cycle after oe_n falls.
  - data_o = RX head word.
  - Pop when rd_n=0, oe_n=0, data_oe=1, and RX not empty.
  - Zero-latency streaming: one word per cycle while rd_n is held low.
  - rd_n low with RX empty: no pop, data_o holds the last word, no error.
- Write path:
  - Push {ft601_data_i, ft601_be_i} when wr_n=0, txe_n=0 (registered value in the same cycle), and TX not full.
  - wr_n=0 with txe_n=1 or TX full: the word is dropped; the margin makes this unreachable for compliant masters.
- proto_err is set (sticky until reset) on either violation:
  - wr_n=0 and oe_n=0 in the same cycle;
  - rd_n=0 while oe_n=1.
- Simultaneous host push and FPGA pop on RX are both honoured, and likewise for TX.
- Reset mid-burst: flags go high and data_oe=0 immediately, per asynchronous rst.

Optional Feature:
- Macro PCILEECH_FT601_EMU_THROTTLE_EN.
- Defined:
  - A 16-bit LFSR (seed 16'hACE1, advancing every cycle) forces rxf_n=1 and txe_n=1 when lfsr[2:0]==0, i.e. 1 in 8 cycles.
  - Transfers are gated on the forced flag values.
  - Stresses master backpressure handling.
- Undefined: no LFSR logic; flags are derived from FIFO occupancy only.

Decomposition:
- Package pcileech_ft601_emu_pkg holds:
  - FSM state enum (IDLE, RD_TURN, RD_ACTIVE, WR_ACTIVE);
  - word/BE width constants (32/4);
  - LFSR seed constant.
- One sub-module, pcileech_ft601_emu_fifo: synchronous FWFT FIFO with parameters WIDTH and DEPTH_LOG2, a count output and a sync flush input.
  - Instantiated twice: RX at 32 bits, TX at 36 bits.

Test Plan:
- Host pushes 3 words 0x11111111..0x33333333; master oe_n low then rd_n low 3 cycles -> data_oe after 1 cycle, words in order, rxf_n=1 on the cycle after the 3rd pop.
- Master writes 0xDEADBEEF (be=4'h3) then 0xCAFEBABE (be=4'hf) -> host_tx_valid, host_tx_data/host_tx_be match, in order.
- Fill TX to 508 words (DEPTH 512, margin 4) -> txe_n=1 next cycle; host pops 1 -> txe_n=0 next cycle.
- Assert wr_n=0 and oe_n=0 together -> proto_err=1 and stays 1 until rst.
- Mid-read burst, assert rst asynchronously -> rxf_n=1 and data_oe=0 before the next edge; RX empty after release.
- With PCILEECH_FT601_EMU_THROTTLE_EN, stream 1000 words each way -> all words delivered intact, proto_err=0.
